dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the five-stage pipeline. It sits on the far side of the MEM stage's load/store port. It accepts one request at a time over a valid/ready request channel, applies a byte-masked write or performs a read after a programmable access latency, and returns the result over a valid/ready response channel. It stands in for the data RAM in simulation and in FPGA builds, and is the block the MEM stage is verified against.

## Interface
- DATA_W, 64, data and address width; equals `width
- DEPTH, 4096, number of DATA_W-bit words stored
- BASE_ADDR, 64'h8000_0000, byte address of word 0
- LATENCY, 1, cycles from request acceptance to response; legal range 1..15
- sys_clk  in  1  clock; all logic on the rising edge
- sys_rst  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  DATA_W  byte address
- req_wdata  in  DATA_W  store data, already lane-aligned
- req_wmask  in  8  per-byte store enable; bit i enables bits 8i+7:8i
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts the response
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors
- rsp_err  out  1  the access was misaligned or out of range

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - req_ready = 1.
  - On req_valid && req_ready: capture we, addr, wdata and wmask, and load cnt = LATENCY-1.
  - Next state is RESP if LATENCY == 1, otherwise WAIT.
- **WAIT**
  - req_ready = 0. cnt decrements each cycle.
  - At the edge where cnt == 1: perform the access and go to RESP.
- **Access**, performed on the edge that enters RESP:
  - idx = (addr - BASE_ADDR) >> 3.
  - err = (addr[2:0] != 0) || (addr < BASE_ADDR) || (idx >= DEPTH).
  - Store, no error: write the bytes enabled by wmask. wmask == 0 is legal and writes nothing.
  - Load, no error: rsp_rdata = mem[idx].
  - Error: no write, and rsp_rdata = 0.
- **RESP**
  - rsp_valid = 1, and rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE and clear rsp_rdata and rsp_err to 0.
- Only one transaction is outstanding at a time. req_* inputs are ignored outside IDLE.
- Memory contents are not reset. They hold their value across sys_rst.

## Timing
- **Reset values** while sys_rst == 0 at an edge:
  - state = IDLE, cnt = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 0 for the whole cycle in which sys_rst is low. It is gated combinationally by sys_rst.
- **Latency:** a request accepted at edge E0 has rsp_valid high starting from edge E0+(LATENCY-1).
  - LATENCY = 1 gives rsp_valid in the cycle directly after the acceptance cycle.
- **Bubble after response:** the response handshake at edge E1 gives req_ready = 1 from E1 on.
  - The earliest next acceptance is at edge E1+1.
  - Back-to-back throughput is one transaction per LATENCY+1 cycles.
- **Response backpressure:** rsp_ready low holds RESP indefinitely, with outputs unchanged.
- **Reset mid-operation:**
  - Reset in WAIT drops the transaction, and a pending store is never written.
  - Reset in RESP discards the response; the store has already committed.
- **Read-after-write:** a load to an address just stored returns the new data, because accesses are strictly serialized.

## Structure
- Add to para.v:
  - `width, reused unchanged.
  - FSM state encodings: 2-bit IDLE/WAIT/RESP.
  - The default BASE_ADDR constant.
- One sub-module, dmem_array: a DEPTH×DATA_W synchronous RAM with a byte write mask and one read/write port, with no reset.
- The FSM, counter, address decode and response registers stay in dmem_responder.

## Test plan
- **Full store then load.** LATENCY = 1. Store addr 0x8000_0010, wdata 0x1122334455667788, wmask 0xFF. Then load the same address.
  - Both responses arrive one cycle after acceptance.
  - Load returns 0x1122334455667788 with rsp_err = 0.
- **Partial byte mask.** Prefill the word with 0xFF…FF. Store wdata 0 with wmask 0x0F.
  - Load returns 0xFFFFFFFF00000000.
- **Access latency.** LATENCY = 4. Hold req_valid for one request.
  - rsp_valid rises exactly 4 cycles after the acceptance cycle.
  - req_ready stays 0 from acceptance until the response handshake.
- **Errors.**
  - Load at 0x8000_0004 (misaligned): rsp_err = 1, rsp_rdata = 0.
  - Store at 0x7FFF_FFF8 (below base): rsp_err = 1, and a following aligned load shows no memory change.
  - Store at BASE_ADDR + 8·DEPTH (past the end): rsp_err = 1, and a following aligned load shows no memory change.
- **Backpressure and throughput.** Hold rsp_ready = 0 for 5 cycles in RESP.
  - rsp_valid and rsp_rdata stay stable throughout.
  - After the handshake, the next acceptance happens no earlier than one cycle later.
- **Reset mid-transaction.** Assert sys_rst = 0 during WAIT of a store of 0xAB to a word previously 0.
  - After reset: req_ready = 1 and rsp_valid = 0.
  - A load of that word returns 0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared constants and FSM encoding for the data-memory responder.
// Imported by the responder top and its RAM sub-module.
package dmem_responder_pkg;

  localparam int          WIDTH             = 64;
  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with a per-byte write mask and a registered read.
// The read register only updates on an enabled load, so it holds between accesses.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter  int DATA_W = WIDTH,
  parameter  int DEPTH  = 4096,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_en,
  input  logic                i_we,
  input  logic [AW-1:0]       i_idx,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wmask,
  output logic [DATA_W-1:0]   o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the storage array and its read register deliberately have no reset;
  // a reset would block RAM inference and contents must survive sys_rst anyway.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (i_wmask[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, programmable access latency,
// byte-masked stores, error reporting for misaligned or out-of-range addresses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DATA_W    = WIDTH,
  parameter int          DEPTH     = 4096,
  parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          LATENCY   = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_e            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_we, r_err, r_rd_ok;
  logic [DATA_W-1:0] r_addr, r_wdata;
  logic [7:0]        r_wmask;

  logic              w_acc_we, w_err, w_access, w_accept, w_req_ready, w_rsp_valid;
  logic [DATA_W-1:0] w_acc_addr, w_acc_wdata, w_off, w_ram_rdata;
  logic [7:0]        w_acc_wmask;

  // With LATENCY == 1 the access happens on the accepting edge, so it must use
  // the live request rather than the captured copy.
  assign w_acc_we    = (r_state == ST_IDLE) ? req_we    : r_we;
  assign w_acc_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
  assign w_acc_wmask = (r_state == ST_IDLE) ? req_wmask : r_wmask;

  assign w_off = w_acc_addr - DATA_W'(BASE_ADDR);
  assign w_err = (w_acc_addr[2:0] != 3'b000) || (w_acc_addr < DATA_W'(BASE_ADDR)) ||
                 ({3'b000, w_off[DATA_W-1:3]} >= DATA_W'(DEPTH));

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_req_ready = sys_rst;
        if (req_valid && sys_rst) w_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: if (r_cnt == 4'd1) w_next = ST_RESP;
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && req_valid && sys_rst;
  assign w_access = sys_rst && (w_next == ST_RESP) && (r_state != ST_RESP);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept)                 r_cnt <= 4'(LATENCY - 1);
      else if (r_state == ST_WAIT)  r_cnt <= r_cnt - 4'd1;
      if (w_access) begin
        r_err   <= w_err;
        r_rd_ok <= !w_acc_we && !w_err;
      end else if (w_rsp_valid && rsp_ready) begin
        r_err   <= 1'b0;
        r_rd_ok <= 1'b0;
      end
    end
  end

  // Captured request is pure datapath; it is only consumed after an accept.
  always_ff @(posedge sys_clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wmask <= req_wmask;
    end
  end

  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .i_clk   (sys_clk),
    .i_en    (w_access && !w_err),
    .i_we    (w_acc_we),
    .i_idx   (w_off[AW+2:3]),
    .i_wdata (w_acc_wdata),
    .i_wmask (w_acc_wmask),
    .o_rdata (w_ram_rdata)
  );

  assign req_ready = w_req_ready;
  assign rsp_valid = w_rsp_valid;
  assign rsp_err   = r_err;
  assign rsp_rdata = r_rd_ok ? w_ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 runs LATENCY=1, instance 1 LATENCY=4.
module tb_dmem_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] LAST = 64'h8000_7FF8;
  localparam logic [63:0] PAST = 64'h8000_8000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [63:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic [7:0]  req_wmask [2];
  logic [63:0] rsp_rdata [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(1)) u_dut1 (
    .sys_clk(clk), .sys_rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.LATENCY(4)) u_dut4 (
    .sys_clk(clk), .sys_rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // One full transaction on instance s. lat counts edges after acceptance until
  // rsp_valid is seen; leak flags req_ready high between acceptance and handshake.
  task automatic txn(input int s, input logic we, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [7:0] mask,
                     output logic [63:0] rdata, output logic err,
                     output int lat, output logic leak);
    int guard = 0;
    @(negedge clk);
    req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = addr;
    req_wdata[s] = wdata; req_wmask[s] = mask;
    while (req_ready[s] !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    if (guard >= 20) begin
      n_checks++;
      $display("FAIL txn_accept_timeout inst=%0d req_ready=%b", s, req_ready[s]);
    end
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    lat = 0; leak = 1'b0;
    while (rsp_valid[s] !== 1'b1 && lat < 40) begin
      if (req_ready[s] !== 1'b0) leak = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (req_ready[s] !== 1'b0) leak = 1'b1;
    rdata = rsp_rdata[s]; err = rsp_err[s];
    if (rsp_valid[s] !== 1'b1) begin
      n_checks++;
      $display("FAIL txn_rsp_timeout inst=%0d rsp_valid=%b", s, rsp_valid[s]);
    end
    rsp_ready[s] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '0; req_we = '0; rsp_ready = '0;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0; req_wmask[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 2'b00) $display("FAIL reset_req_ready got=%b exp=00", req_ready);
    else n_pass++;
    n_checks++;
    if (rsp_valid !== 2'b00 || rsp_err !== 2'b00)
      $display("FAIL reset_rsp got valid=%b err=%b exp 00/00", rsp_valid, rsp_err);
    else n_pass++;
    n_checks++;
    if (rsp_rdata[0] !== 64'h0 || rsp_rdata[1] !== 64'h0)
      $display("FAIL reset_rdata got=%h/%h exp=0", rsp_rdata[0], rsp_rdata[1]);
    else n_pass++;
    @(negedge clk); rst = 1'b1; #1;
    n_checks++;
    if (req_ready !== 2'b11) $display("FAIL reset_release_ready got=%b exp=11", req_ready);
    else n_pass++;
  endtask

  task automatic test_full_store_load();
    logic [63:0] d; logic e, lk; int lat;
    txn(0, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, d, e, lat, lk);
    n_checks++;
    if (lat !== 0 || e !== 1'b0 || d !== 64'h0)
      $display("FAIL store_full got lat=%0d err=%b rdata=%h exp 0/0/0", lat, e, d);
    else n_pass++;
    txn(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, d, e, lat, lk);
    n_checks++;
    if (lat !== 0 || e !== 1'b0 || d !== 64'h1122_3344_5566_7788)
      $display("FAIL load_full got lat=%0d err=%b rdata=%h exp 0/0/1122334455667788", lat, e, d);
    else n_pass++;
  endtask

  task automatic test_partial_mask();
    logic [63:0] d; logic e, lk; int lat;
    txn(0, 1'b1, 64'h8000_0018, '1, 8'hFF, d, e, lat, lk);
    txn(0, 1'b1, 64'h8000_0018, 64'h0, 8'h0F, d, e, lat, lk);
    txn(0, 1'b0, 64'h8000_0018, 64'h0, 8'h00, d, e, lat, lk);
    n_checks++;
    if (d !== 64'hFFFF_FFFF_0000_0000 || e !== 1'b0)
      $display("FAIL partial_mask got=%h err=%b exp=ffffffff00000000/0", d, e);
    else n_pass++;
    txn(0, 1'b1, 64'h8000_0018, 64'h0, 8'h00, d, e, lat, lk);
    txn(0, 1'b0, 64'h8000_0018, 64'h0, 8'h00, d, e, lat, lk);
    n_checks++;
    if (d !== 64'hFFFF_FFFF_0000_0000)
      $display("FAIL zero_mask got=%h exp=ffffffff00000000", d);
    else n_pass++;
  endtask

  task automatic test_latency();
    logic [63:0] d; logic e, lk; int lat;
    txn(1, 1'b1, 64'h8000_0200, 64'h5A5A_0123_4567_A5A5, 8'hFF, d, e, lat, lk);
    n_checks++;
    if (lat !== 3 || lk !== 1'b0 || e !== 1'b0)
      $display("FAIL latency_store got lat=%0d leak=%b err=%b exp 3/0/0", lat, lk, e);
    else n_pass++;
    txn(1, 1'b0, 64'h8000_0200, 64'h0, 8'h00, d, e, lat, lk);
    n_checks++;
    if (lat !== 3 || lk !== 1'b0 || d !== 64'h5A5A_0123_4567_A5A5)
      $display("FAIL latency_load got lat=%0d leak=%b rdata=%h exp 3/0/5a5a01234567a5a5", lat, lk, d);
    else n_pass++;
  endtask

  task automatic test_errors();
    logic [63:0] d; logic e, lk; int lat;
    txn(0, 1'b1, BASE, 64'h0123_4567_89AB_CDEF, 8'hFF, d, e, lat, lk);
    txn(0, 1'b1, LAST, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, d, e, lat, lk);
    txn(0, 1'b0, 64'h8000_0004, 64'h0, 8'h00, d, e, lat, lk);
    n_checks++;
    if (e !== 1'b1 || d !== 64'h0) $display("FAIL misaligned got err=%b rdata=%h exp 1/0", e, d);
    else n_pass++;
    txn(0, 1'b1, 64'h7FFF_FFF8, 64'h0, 8'hFF, d, e, lat, lk);
    n_checks++;
    if (e !== 1'b1 || d !== 64'h0) $display("FAIL below_base got err=%b rdata=%h exp 1/0", e, d);
    else n_pass++;
    txn(0, 1'b0, BASE, 64'h0, 8'h00, d, e, lat, lk);
    n_checks++;
    if (e !== 1'b0 || d !== 64'h0123_4567_89AB_CDEF)
      $display("FAIL below_base_nowrite got=%h err=%b exp=0123456789abcdef/0", d, e);
    else n_pass++;
    txn(0, 1'b1, PAST, 64'h0, 8'hFF, d, e, lat, lk);
    n_checks++;
    if (e !== 1'b1 || d !== 64'h0) $display("FAIL past_end got err=%b rdata=%h exp 1/0", e, d);
    else n_pass++;
    txn(0, 1'b0, BASE, 64'h0, 8'h00, d, e, lat, lk);
    n_checks++;
    if (d !== 64'h0123_4567_89AB_CDEF)
      $display("FAIL past_end_word0 got=%h exp=0123456789abcdef", d);
    else n_pass++;
    txn(0, 1'b0, LAST, 64'h0, 8'h00, d, e, lat, lk);
    n_checks++;
    if (e !== 1'b0 || d !== 64'hCAFE_F00D_DEAD_BEEF)
      $display("FAIL last_word got=%h err=%b exp=cafef00ddeadbeef/0", d, e);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] d; logic e, lk, stable; int lat;
    txn(0, 1'b1, 64'h8000_0040, 64'hDEAD_0000_BEEF_1111, 8'hFF, d, e, lat, lk);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 64'h8000_0040;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    stable = (rsp_valid[0] === 1'b1) && (rsp_rdata[0] === 64'hDEAD_0000_BEEF_1111);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 64'hDEAD_0000_BEEF_1111 ||
          rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) stable = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1)
      $display("FAIL backpressure_hold got valid=%b rdata=%h exp 1/dead0000beef1111", rsp_valid[0], rsp_rdata[0]);
    else n_pass++;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    n_checks++;
    if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 64'h0 || req_ready[0] !== 1'b1)
      $display("FAIL after_handshake got valid=%b rdata=%h ready=%b exp 0/0/1", rsp_valid[0], rsp_rdata[0], req_ready[0]);
    else n_pass++;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n_checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 64'hDEAD_0000_BEEF_1111)
      $display("FAIL back_to_back got valid=%b rdata=%h exp 1/dead0000beef1111", rsp_valid[0], rsp_rdata[0]);
    else n_pass++;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic e, lk; int lat;
    txn(1, 1'b1, 64'h8000_0100, 64'h0, 8'hFF, d, e, lat, lk);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 64'h8000_0100;
    req_wdata[1] = 64'hAB; req_wmask[1] = 8'hFF;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready[1] !== 1'b0) $display("FAIL mid_reset_ready_low got=%b exp=0", req_ready[1]);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0)
      $display("FAIL mid_reset_state got ready=%b valid=%b exp 1/0", req_ready[1], rsp_valid[1]);
    else n_pass++;
    txn(1, 1'b0, 64'h8000_0100, 64'h0, 8'h00, d, e, lat, lk);
    n_checks++;
    if (d !== 64'h0 || e !== 1'b0)
      $display("FAIL mid_reset_dropped_store got=%h err=%b exp=0/0", d, e);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_store_load();
    test_partial_mask();
    test_latency();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
